// File: rtl/cp0_ex_ctrl.sv
// Folds the WB exception, pending interrupts and ERET into one registered commit pulse to CP0.
// The commit pulse lands one cycle after sampling. Flush and redirect are then held until fetch accepts.
module cp0_ex_ctrl #(
   parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             ws_valid,
   input  logic             ws_ex,
   input  logic [4:0]       ws_excode,
   input  logic             ws_eret,
   input  logic             ws_bd,
   input  logic [31:0]      ws_pc,
   input  logic [31:0]      ws_badvaddr,
   input  logic [31:0]      cp0_status,
   input  logic [31:0]      cp0_cause,
   input  logic [31:0]      cp0_epc,
   output logic             ws_ready,
   output logic             wb_ex,
   output logic             wb_eret,
   output logic [4:0]       wb_excode,
   output logic             wb_bd,
   output logic [31:0]      wb_pc,
   output logic [31:0]      wb_badvaddr,
   output logic             flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   input  logic             redirect_ready,
   output logic [CNT_W-1:0] ex_cnt
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REDIRECT = 2'd1,
      S_HOLD     = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_wb_ex;
   logic             r_wb_eret;
   logic [4:0]       r_wb_excode;
   logic             r_wb_bd;
   logic [31:0]      r_wb_pc;
   logic [31:0]      r_wb_badvaddr;
   logic             r_redir_vld;
   logic [31:0]      r_redir_pc;
   logic [CNT_W-1:0] r_ex_cnt;

   logic w_int_pend;
   logic w_idle;
   logic w_event;
   logic w_take_int;
   logic w_take_ex;
   logic w_take_eret;
   logic w_unused;

   assign w_int_pend = (|(cp0_cause[15:8] & cp0_status[15:8])) & cp0_status[0] & ~cp0_status[1];
   assign w_idle     = (r_state == S_IDLE);
   assign w_event    = w_idle & ws_valid & (w_int_pend | ws_ex | ws_eret);

   // Interrupt beats the instruction's own exception, which beats ERET.
   assign w_take_int  = w_event & w_int_pend;
   assign w_take_ex   = w_event & ~w_int_pend & ws_ex;
   assign w_take_eret = w_event & ~w_int_pend & ~ws_ex & ws_eret;

   assign w_unused = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_wb_ex       <= 1'b0;
         r_wb_eret     <= 1'b0;
         r_wb_excode   <= 5'd0;
         r_wb_bd       <= 1'b0;
         r_wb_pc       <= 32'd0;
         r_wb_badvaddr <= 32'd0;
         r_redir_vld   <= 1'b0;
         r_redir_pc    <= 32'd0;
         r_ex_cnt      <= '0;
      end else begin
         r_wb_ex   <= w_take_int | w_take_ex;
         r_wb_eret <= w_take_eret;

         case (r_state)
            S_IDLE: begin
               if (w_event) begin
                  r_state     <= S_REDIRECT;
                  r_redir_vld <= 1'b1;
                  r_wb_bd     <= ws_bd;
                  r_wb_pc     <= ws_pc;
                  r_redir_pc  <= w_take_eret ? cp0_epc : EX_ENTRY;
                  if (w_take_int)
                     r_wb_excode <= 5'h00;
                  else if (w_take_ex)
                     r_wb_excode <= ws_excode;
                  if (w_take_ex)
                     r_wb_badvaddr <= ws_badvaddr;
                  if ((w_take_int | w_take_ex) && (r_ex_cnt != {CNT_W{1'b1}}))
                     r_ex_cnt <= r_ex_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            S_REDIRECT: begin
               if (redirect_ready) begin
                  r_state     <= S_HOLD;
                  r_redir_vld <= 1'b0;
               end
            end
            // One dead cycle so CP0's EXL update is visible before interrupts are looked at again.
            S_HOLD: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state     <= S_IDLE;
               r_redir_vld <= 1'b0;
            end
         endcase
      end
   end

   assign ws_ready       = w_idle & ~w_event;
   assign wb_ex          = r_wb_ex;
   assign wb_eret        = r_wb_eret;
   assign wb_excode      = r_wb_excode;
   assign wb_bd          = r_wb_bd;
   assign wb_pc          = r_wb_pc;
   assign wb_badvaddr    = r_wb_badvaddr;
   assign flush          = r_redir_vld;
   assign redirect_valid = r_redir_vld;
   assign redirect_pc    = r_redir_pc;
   assign ex_cnt         = r_ex_cnt;

endmodule

// File: tb/tb_cp0_ex_ctrl.sv
// Directed bench for cp0_ex_ctrl: expected commits are queued at issue time and checked by a monitor on each pulse.
module tb_cp0_ex_ctrl;
   localparam int          CNT_W = 4;
   localparam logic [31:0] EXV   = 32'hBFC0_0380;

   logic             clk = 1'b0;
   logic             resetn;
   logic             ws_valid, ws_ex, ws_eret, ws_bd;
   logic [4:0]       ws_excode;
   logic [31:0]      ws_pc, ws_badvaddr, cp0_status, cp0_cause, cp0_epc;
   logic             ws_ready, wb_ex, wb_eret, wb_bd, flush, redirect_valid, redirect_ready;
   logic [4:0]       wb_excode;
   logic [31:0]      wb_pc, wb_badvaddr, redirect_pc;
   logic [CNT_W-1:0] ex_cnt;

   cp0_ex_ctrl #(.EX_ENTRY(EXV), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn),
      .ws_valid(ws_valid), .ws_ex(ws_ex), .ws_excode(ws_excode), .ws_eret(ws_eret),
      .ws_bd(ws_bd), .ws_pc(ws_pc), .ws_badvaddr(ws_badvaddr),
      .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
      .ws_ready(ws_ready), .wb_ex(wb_ex), .wb_eret(wb_eret), .wb_excode(wb_excode),
      .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .ex_cnt(ex_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ex;
      logic        eret;
      logic        chk_code;
      logic [4:0]  code;
      logic        bd;
      logic [31:0] pc;
      logic [31:0] bad;
      logic [31:0] rpc;
      logic [3:0]  cnt;
   } exp_t;

   exp_t     q[$];
   int       checks = 0;
   int       errors = 0;
   int       m_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every commit pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (resetn === 1'b1 && (wb_ex === 1'b1 || wb_eret === 1'b1)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: wb_ex=%b wb_eret=%b pc=%h with nothing expected", wb_ex, wb_eret, wb_pc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("wb_ex", {31'd0, wb_ex}, {31'd0, e.ex});
            chk("wb_eret", {31'd0, wb_eret}, {31'd0, e.eret});
            if (e.chk_code) chk("wb_excode", {27'd0, wb_excode}, {27'd0, e.code});
            chk("wb_bd", {31'd0, wb_bd}, {31'd0, e.bd});
            chk("wb_pc", wb_pc, e.pc);
            chk("wb_badvaddr", wb_badvaddr, e.bad);
            chk("redirect_pc", redirect_pc, e.rpc);
            chk("redirect_valid_at_commit", {31'd0, redirect_valid}, 32'd1);
            chk("ex_cnt", {28'd0, ex_cnt}, {28'd0, e.cnt});
         end
      end
   end

   task automatic clear_ws();
      ws_valid = 1'b0; ws_ex = 1'b0; ws_eret = 1'b0; ws_bd = 1'b0;
      ws_excode = 5'd0; ws_pc = 32'd0; ws_badvaddr = 32'd0;
      cp0_status = 32'd0; cp0_cause = 32'd0;
   endtask

   task automatic push_exp(input logic ex, input logic eret, input logic [4:0] code, input logic bd,
                           input logic [31:0] pc, input logic [31:0] bad, input logic [31:0] rpc);
      exp_t e;
      if (ex) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
      e.ex = ex; e.eret = eret; e.chk_code = ex; e.code = code; e.bd = bd;
      e.pc = pc; e.bad = bad; e.rpc = rpc; e.cnt = m_cnt[3:0];
      q.push_back(e);
   endtask

   // Called one step after the commit edge: stall fetch, then accept, then pass through HOLD.
   task automatic finish_redirect(input int stall);
      for (int i = 0; i < stall; i++) begin
         chk("flush_stall", {31'd0, flush}, 32'd1);
         chk("ws_ready_stall", {31'd0, ws_ready}, 32'd0);
         @(posedge clk); #1;
      end
      chk("redirect_valid_before_accept", {31'd0, redirect_valid}, 32'd1);
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      chk("flush_hold", {31'd0, flush}, 32'd0);
      chk("ws_ready_hold", {31'd0, ws_ready}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic ev(input logic ex, input logic [4:0] code, input logic eret, input logic bd,
                     input logic [31:0] pc, input logic [31:0] bad, input logic [31:0] st,
                     input logic [31:0] ca, input logic [31:0] epc, input int stall);
      ws_valid = 1'b1; ws_ex = ex; ws_excode = code; ws_eret = eret; ws_bd = bd;
      ws_pc = pc; ws_badvaddr = bad; cp0_status = st; cp0_cause = ca; cp0_epc = epc;
      #1 chk("ws_ready_on_event", {31'd0, ws_ready}, 32'd0);
      @(posedge clk); #1;
      clear_ws();
      cp0_epc = 32'hFFFF_0000;
      finish_redirect(stall);
   endtask

   initial begin
      resetn = 1'b0; redirect_ready = 1'b0; cp0_epc = 32'd0;
      clear_ws();
      #12;
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_ex_cnt", {28'd0, ex_cnt}, 32'd0);
      chk("rst_wb_pc", wb_pc, 32'd0);
      @(posedge clk); #1 resetn = 1'b1;
      #1 chk("ws_ready_after_reset", {31'd0, ws_ready}, 32'd1);

      // Plain exception
      push_exp(1, 0, 5'h04, 0, 32'h8000_0010, 32'h1, EXV);
      ev(1, 5'h04, 0, 0, 32'h8000_0010, 32'h1, 32'h0, 32'h0, 32'h0, 2);
      // ERET with a 5-cycle fetch stall; badvaddr holds
      push_exp(0, 1, 5'h00, 1, 32'h8000_0040, 32'h1, 32'h8000_1234);
      ev(0, 5'h00, 1, 1, 32'h8000_0040, 32'h55, 32'h0, 32'h0, 32'h8000_1234, 5);
      // Interrupt beats ws_ex; badvaddr not taken from the losing exception
      push_exp(1, 0, 5'h00, 0, 32'h8000_0020, 32'h1, EXV);
      ev(1, 5'h0C, 0, 0, 32'h8000_0020, 32'hDEAD, 32'h0000_8001, 32'h0000_8000, 32'h0, 0);
      // Same with EXL set: interrupt masked, exception wins
      push_exp(1, 0, 5'h0C, 1, 32'h8000_0024, 32'hDEAD, EXV);
      ev(1, 5'h0C, 0, 1, 32'h8000_0024, 32'hDEAD, 32'h0000_8003, 32'h0000_8000, 32'h0, 1);
      // Interrupt beats ERET
      push_exp(1, 0, 5'h00, 0, 32'h8000_0030, 32'hDEAD, EXV);
      ev(0, 5'h00, 1, 0, 32'h8000_0030, 32'h77, 32'h0000_8001, 32'h0000_8000, 32'h8000_9999, 0);

      // Exceptions presented during REDIRECT and HOLD are ignored until IDLE
      push_exp(1, 0, 5'h04, 0, 32'h8000_0044, 32'h44, EXV);
      ws_valid = 1'b1; ws_ex = 1'b1; ws_excode = 5'h04; ws_pc = 32'h8000_0044; ws_badvaddr = 32'h44;
      @(posedge clk); #1;
      ws_excode = 5'h0A; ws_pc = 32'h8000_0100; ws_badvaddr = 32'h100;
      chk("ws_ready_redirect_busy", {31'd0, ws_ready}, 32'd0);
      @(posedge clk); #1;
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      chk("ws_ready_hold_busy", {31'd0, ws_ready}, 32'd0);
      @(posedge clk); #1;
      push_exp(1, 0, 5'h0A, 0, 32'h8000_0100, 32'h100, EXV);
      chk("ws_ready_idle_event", {31'd0, ws_ready}, 32'd0);
      @(posedge clk); #1;
      clear_ws();
      finish_redirect(0);

      // Saturation: 2^CNT_W+3 exceptions
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         push_exp(1, 0, 5'h05, 0, 32'h8000_1000 + 32'(i * 4), 32'(i), EXV);
         ev(1, 5'h05, 0, 0, 32'h8000_1000 + 32'(i * 4), 32'(i), 32'h0, 32'h0, 32'h0, 0);
      end
      chk("ex_cnt_saturated", {28'd0, ex_cnt}, 32'd15);

      // Reset mid-REDIRECT clears outputs immediately
      ws_valid = 1'b1; ws_ex = 1'b1; ws_excode = 5'h07; ws_pc = 32'h8000_2000;
      @(posedge clk); #1;
      clear_ws();
      chk("redirect_valid_pre_reset", {31'd0, redirect_valid}, 32'd1);
      resetn = 1'b0;
      m_cnt = 0;
      #1;
      chk("mid_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("mid_rst_flush", {31'd0, flush}, 32'd0);
      chk("mid_rst_wb_ex", {31'd0, wb_ex}, 32'd0);
      chk("mid_rst_redirect_pc", redirect_pc, 32'd0);
      chk("mid_rst_ex_cnt", {28'd0, ex_cnt}, 32'd0);
      @(posedge clk); #1 resetn = 1'b1;
      #1 chk("ws_ready_after_mid_reset", {31'd0, ws_ready}, 32'd1);
      push_exp(1, 0, 5'h08, 0, 32'h8000_3000, 32'h30, EXV);
      ev(1, 5'h08, 0, 0, 32'h8000_3000, 32'h30, 32'h0, 32'h0, 32'h0, 0);

      repeat (3) @(posedge clk);
      #1 chk("scoreboard_drained", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
